// File: rtl/beta_share_pkg.sv
// beta_share_pkg: definitions shared by the beta frame-share block.
//   - position of the control-window select bit within a byte address
//   - bit offsets of the fields in the status word
//   - FSM state encoding and the command bit used by swap / frame_done
//   - helper that advances the host back-buffer pointer around the ring
package beta_share_pkg;

  // Buffer pointers are 2 bits wide, enough for a ring of up to 4 buffers.
  localparam int IDX_W = 2;

  // Status word layout, LSB first.
  localparam int ST_PEND_LSB = 0;
  localparam int ST_WR_LSB   = 1;
  localparam int ST_RD_LSB   = 3;
  localparam int ST_CNT_LSB  = 5;
  localparam int OVR_W       = 8;

  // Bit of the control-register write data that carries swap / frame_done.
  localparam int CMD_BIT = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } share_state_e;

  // Byte address bit that selects the control window instead of buffer data.
  function automatic int ctrl_bit_pos(input int depth_log2);
    return depth_log2 + 2;
  endfunction

  // Next back buffer: one step around the ring, never landing on the buffer
  // that has just become the client's front buffer.
  function automatic logic [IDX_W-1:0] next_wr_idx(input logic [IDX_W-1:0] wr,
                                                   input logic [IDX_W-1:0] new_rd,
                                                   input int num_bufs);
    logic [IDX_W-1:0] n;
    n = (wr == IDX_W'(num_bufs - 1)) ? '0 : wr + 1'b1;
    if (n == new_rd) begin
      n = (n == IDX_W'(num_bufs - 1)) ? '0 : n + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_ring_ram.sv
// frame_ring_ram: storage for all frame buffers of the ring.
//   Port A (host):   read/write, a_addr/a_we/a_din in, a_dout out.
//   Port B (client): read-only,  b_addr in, b_dout out.
//   Addresses are {buf_idx, word_idx}. Both reads are registered (1 cycle).
//   No reset: contents and read registers are left to the block RAM.
module frame_ring_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = 2048
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout
);

  logic [DATA_W-1:0] mem [NUM_WORDS];
  logic [DATA_W-1:0] a_dout_q;
  logic [DATA_W-1:0] b_dout_q;

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_din;
    end
    a_dout_q <= mem[a_addr];
    b_dout_q <= mem[b_addr];
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;

endmodule

// File: rtl/beta_frame_share.sv
// beta_frame_share: rotating frame buffers shared between the physics beta
// (host) and the laser beta (client), with a control/status window per side.
//   clk, reset               : clock, synchronous active-high reset
//   host_addr/din/mwe/dout   : host data + control port (reads the back buffer)
//   client_addr/din/mwe/dout : client port (reads the front buffer; only the
//                              control window is writable)
//   irq_client               : one-cycle pulse after every committed swap
//   swap_pending             : host swap waiting for client frame_done
module beta_frame_share
  import beta_share_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int NUM_BUFS   = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_mwe,
  output logic [DATA_W-1:0] host_dout,
  input  logic [31:0]       client_addr,
  input  logic [DATA_W-1:0] client_din,
  input  logic              client_mwe,
  output logic [DATA_W-1:0] client_dout,
  output logic              irq_client,
  output logic              swap_pending
);

  localparam int CB     = ctrl_bit_pos(DEPTH_LOG2);
  localparam int ADDR_W = IDX_W + DEPTH_LOG2;

  share_state_e          state_q;
  logic [IDX_W-1:0]      wr_idx_q, rd_idx_q;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic [OVR_W-1:0]      overrun_q;
  logic                  irq_q;
  logic                  host_sel_ctrl_q, client_sel_ctrl_q;
  logic [DATA_W-1:0]     host_stat_q, client_stat_q;

  logic [DEPTH_LOG2-1:0] host_word, client_word;
  logic                  host_ctrl, client_ctrl;
  logic                  swap_req, frame_done, commit;
  logic [DATA_W-1:0]     status;
  logic [DATA_W-1:0]     ram_host_dout, ram_client_dout;

  assign host_word   = host_addr[CB-1:2];
  assign host_ctrl   = host_addr[CB];
  assign client_word = client_addr[CB-1:2];
  assign client_ctrl = client_addr[CB];

  assign swap_req   = host_mwe & host_ctrl & (host_word == '0) & host_din[CMD_BIT];
  assign frame_done = client_mwe & client_ctrl & (client_word == '0) & client_din[CMD_BIT];

  // A frame_done only commits if a swap is waiting or arrives on the same edge.
  assign commit = frame_done & ((state_q == ST_PENDING) | swap_req);

  always_comb begin
    status = '0;
    status[ST_PEND_LSB]                 = (state_q == ST_PENDING);
    status[ST_WR_LSB +: IDX_W]          = wr_idx_q;
    status[ST_RD_LSB +: IDX_W]          = rd_idx_q;
    status[ST_CNT_LSB +: CNT_W]         = frame_cnt_q;
    status[ST_CNT_LSB + CNT_W +: OVR_W] = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      wr_idx_q          <= IDX_W'(1);
      rd_idx_q          <= '0;
      frame_cnt_q       <= '0;
      overrun_q         <= '0;
      irq_q             <= 1'b0;
      // Selecting the (cleared) status path makes both douts read 0 in reset
      // without having to reset the RAM output registers.
      host_sel_ctrl_q   <= 1'b1;
      host_stat_q       <= '0;
      client_sel_ctrl_q <= 1'b1;
      client_stat_q     <= '0;
    end else begin
      irq_q             <= commit;
      host_sel_ctrl_q   <= host_ctrl;
      host_stat_q       <= (host_word == '0) ? status : '0;
      client_sel_ctrl_q <= client_ctrl;
      client_stat_q     <= (client_word == '0) ? status : '0;

      if (commit) begin
        rd_idx_q    <= wr_idx_q;
        wr_idx_q    <= next_wr_idx(wr_idx_q, wr_idx_q, NUM_BUFS);
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end

      if (swap_req && (state_q == ST_PENDING) && (overrun_q != '1)) begin
        overrun_q <= overrun_q + 1'b1;
      end

      case (state_q)
        ST_IDLE:    if (swap_req && !frame_done) state_q <= ST_PENDING;
        ST_PENDING: if (frame_done) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  frame_ring_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_BUFS << DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .a_addr ({wr_idx_q, host_word}),
    .a_we   (host_mwe & ~host_ctrl),
    .a_din  (host_din),
    .a_dout (ram_host_dout),
    .b_addr ({rd_idx_q, client_word}),
    .b_dout (ram_client_dout)
  );

  assign host_dout    = host_sel_ctrl_q ? host_stat_q : ram_host_dout;
  assign client_dout  = client_sel_ctrl_q ? client_stat_q : ram_client_dout;
  assign irq_client   = irq_q;
  assign swap_pending = (state_q == ST_PENDING);

  // Address bits outside the word index / control select, and client write
  // data above the command bit, carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{host_addr[31:CB+1], host_addr[1:0],
                         client_addr[31:CB+1], client_addr[1:0],
                         client_din[DATA_W-1:1]};

endmodule

// File: tb/tb_beta_frame_share.sv
// Testbench for beta_frame_share: directed stimulus; read expectations go
// into per-port queues and a monitor compares them one cycle after issue.
module tb_beta_frame_share;

  localparam int DW = 32;
  localparam int D  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   h_addr, c_addr, h2_addr, c2_addr;
  logic [DW-1:0] h_din, c_din, h2_din, c2_din;
  logic          h_mwe, c_mwe, h2_mwe, c2_mwe;
  logic [DW-1:0] h_dout, c_dout, h2_dout, c2_dout;
  logic          irq, pend, irq2, pend2;

  beta_frame_share #(.DATA_W(DW), .DEPTH_LOG2(D), .NUM_BUFS(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .host_addr(h_addr), .host_din(h_din), .host_mwe(h_mwe), .host_dout(h_dout),
    .client_addr(c_addr), .client_din(c_din), .client_mwe(c_mwe), .client_dout(c_dout),
    .irq_client(irq), .swap_pending(pend));

  beta_frame_share #(.DATA_W(DW), .DEPTH_LOG2(D), .NUM_BUFS(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset),
    .host_addr(h2_addr), .host_din(h2_din), .host_mwe(h2_mwe), .host_dout(h2_dout),
    .client_addr(c2_addr), .client_din(c2_din), .client_mwe(c2_mwe), .client_dout(c2_dout),
    .irq_client(irq2), .swap_pending(pend2));

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t hq[$];
  exp_t cq[$];
  exp_t h2q[$];
  logic h_rd = 1'b0, c_rd = 1'b0, h2_rd = 1'b0;

  function automatic logic [31:0] mk_addr(input bit ctrl, input int word);
    logic [31:0] a;
    logic [31:0] w;
    w = word;
    a = '0;
    a[D+2]   = ctrl;
    a[D+1:2] = w[D-1:0];
    return a;
  endfunction

  function automatic logic [31:0] st(input int ov, input int cnt, input int rd,
                                     input int wr, input bit pnd);
    logic [31:0] s;
    s = 32'(pnd) | (32'(wr) << 1) | (32'(rd) << 3) | (32'(cnt) << 5) | (32'(ov) << 21);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor: a read issued before this edge is presented 1 cycle later.
  always @(posedge clk) begin : monitor
    bit   hv, cv, h2v;
    exp_t e;
    hv = h_rd; cv = c_rd; h2v = h2_rd;
    #1;
    if (hv) begin
      if (hq.size() == 0) begin errors++; checks++; $display("FAIL host_unexpected_read: got %h", h_dout); end
      else begin e = hq.pop_front(); check(e.name, h_dout, e.exp); end
    end
    if (cv) begin
      if (cq.size() == 0) begin errors++; checks++; $display("FAIL client_unexpected_read: got %h", c_dout); end
      else begin e = cq.pop_front(); check(e.name, c_dout, e.exp); end
    end
    if (h2v) begin
      if (h2q.size() == 0) begin errors++; checks++; $display("FAIL host3_unexpected_read: got %h", h2_dout); end
      else begin e = h2q.pop_front(); check(e.name, h2_dout, e.exp); end
    end
  end

  always @(posedge clk) if (irq === 1'b1) irq_cnt++;

  // All tasks start at a negedge and return at the following negedge.
  task automatic h_write(input bit ctrl, input int word, input logic [31:0] d);
    h_addr = mk_addr(ctrl, word); h_din = d; h_mwe = 1'b1;
    @(negedge clk); h_mwe = 1'b0;
  endtask

  task automatic c_write(input bit ctrl, input int word, input logic [31:0] d);
    c_addr = mk_addr(ctrl, word); c_din = d; c_mwe = 1'b1;
    @(negedge clk); c_mwe = 1'b0;
  endtask

  task automatic h_read(input bit ctrl, input int word, input logic [31:0] e, input string n);
    h_addr = mk_addr(ctrl, word); h_rd = 1'b1; hq.push_back('{exp: e, name: n});
    @(negedge clk); h_rd = 1'b0;
  endtask

  task automatic c_read(input bit ctrl, input int word, input logic [31:0] e, input string n);
    c_addr = mk_addr(ctrl, word); c_rd = 1'b1; cq.push_back('{exp: e, name: n});
    @(negedge clk); c_rd = 1'b0;
  endtask

  task automatic h2_read(input bit ctrl, input int word, input logic [31:0] e, input string n);
    h2_addr = mk_addr(ctrl, word); h2_rd = 1'b1; h2q.push_back('{exp: e, name: n});
    @(negedge clk); h2_rd = 1'b0;
  endtask

  // Swap request and frame_done on the same edge.
  task automatic sync_swap(input bit on_ring3);
    if (on_ring3) begin
      h2_addr = mk_addr(1, 0); h2_din = 1; h2_mwe = 1'b1;
      c2_addr = mk_addr(1, 0); c2_din = 1; c2_mwe = 1'b1;
    end else begin
      h_addr = mk_addr(1, 0); h_din = 1; h_mwe = 1'b1;
      c_addr = mk_addr(1, 0); c_din = 1; c_mwe = 1'b1;
    end
    @(negedge clk);
    h_mwe = 1'b0; c_mwe = 1'b0; h2_mwe = 1'b0; c2_mwe = 1'b0;
  endtask

  initial begin
    int pc;
    int rs[4];
    int ws[4];
    rs = '{1, 2, 0, 1};
    ws = '{2, 0, 1, 2};
    h_addr = '0; c_addr = '0; h2_addr = '0; c2_addr = '0;
    h_din = '0; c_din = '0; h2_din = '0; c2_din = '0;
    h_mwe = 0; c_mwe = 0; h2_mwe = 0; c2_mwe = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_host_dout", h_dout, 0);
    check("rst_client_dout", c_dout, 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_pending", 32'(pend), 0);
    check("rst_host3_dout", h2_dout, 0);
    reset = 1'b0;

    // 1: status after reset
    c_read(1, 0, st(0, 0, 0, 1, 0), "t1_client_status");
    h_read(1, 0, st(0, 0, 0, 1, 0), "t1_host_status");
    h_read(1, 3, 32'h0, "t1_other_ctrl_word");

    // 2: write, swap, frame_done after 10 cycles
    h_write(0, 5, 32'hDEADBEEF);
    h_read(0, 5, 32'hDEADBEEF, "t2_host_readback");
    h_write(1, 0, 1);
    pc = 0;
    repeat (10) begin
      if (pend) pc++;
      @(negedge clk);
    end
    check("t2_pending_cycles", pc, 10);
    c_write(1, 0, 1);
    check("t2_irq_after_done", 32'(irq), 1);
    @(negedge clk);
    check("t2_irq_one_cycle", 32'(irq), 0);
    c_read(0, 5, 32'hDEADBEEF, "t2_client_word5");
    c_read(1, 0, st(0, 1, 1, 0, 0), "t2_status");
    check("t2_irq_count", irq_cnt, 1);
    c_write(0, 5, 32'hFFFFFFFF);
    c_read(0, 5, 32'hDEADBEEF, "t2_client_write_ignored");

    // 3: zero-wait swap
    h_write(0, 5, 32'hCAFEF00D);
    sync_swap(1'b0);
    check("t3_no_pending", 32'(pend), 0);
    check("t3_irq", 32'(irq), 1);
    c_read(0, 5, 32'hCAFEF00D, "t3_client_new_front");
    h_read(0, 5, 32'hDEADBEEF, "t3_host_new_back");
    h_read(1, 0, st(0, 2, 0, 1, 0), "t3_status");
    check("t3_irq_count", irq_cnt, 2);

    // 4: overrun while pending, late write joins the pending frame
    h_write(1, 0, 1);
    h_write(0, 7, 32'h12345678);
    repeat (3) h_write(1, 0, 1);
    h_read(1, 0, st(3, 2, 0, 1, 1), "t4_overrun3");
    c_write(1, 0, 1);
    @(negedge clk);
    c_read(1, 0, st(3, 3, 1, 0, 0), "t4_one_commit");
    c_read(0, 7, 32'h12345678, "t4_late_write");
    check("t4_irq_count", irq_cnt, 3);
    h_write(1, 0, 1);
    repeat (300) h_write(1, 0, 1);
    h_read(1, 0, st(255, 3, 1, 0, 1), "t4_overrun_sat");

    // 6: reset while pending
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t6_pending_cleared", 32'(pend), 0);
    c_write(1, 0, 1);
    repeat (3) @(negedge clk);
    check("t6_no_irq", irq_cnt, 3);
    check("t6_still_idle", 32'(pend), 0);
    h_read(1, 0, st(0, 0, 0, 1, 0), "t6_status");
    c_read(0, 5, 32'hCAFEF00D, "t6_ram_kept_front");
    h_read(0, 7, 32'h12345678, "t6_ram_kept_back");

    // 5: three-buffer ring
    for (int i = 0; i < 4; i++) begin
      sync_swap(1'b1);
      check($sformatf("t5_pending_%0d", i), 32'(pend2), 0);
      h2_read(1, 0, st(0, i + 1, rs[i], ws[i], 0), $sformatf("t5_ring_%0d", i));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", hq.size() + cq.size() + h2q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beta_frame_share.md
Name: beta_frame_share

Overview:
- Parametrised successor to the single-buffer host/client shared memory between the physics beta (host) and the laser beta (client).
- Provides NUM_BUFS rotating frame buffers plus a control/status register window on each side.
- Host writes a frame into the back buffer, then requests a swap. The swap commits only when the client signals frame-done, so the laser never draws a half-written frame.
- The client gets a one-cycle irq pulse on every committed swap.

Parameters:
- DATA_W, 32, data word width on both ports.
- DEPTH_LOG2, 10, log2 of words per buffer.
- NUM_BUFS, 2, number of buffers in the ring (legal range 2..4).
- CNT_W, 16, width of the committed-frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- host_addr  in  32  host byte address. [DEPTH_LOG2+1:2] is the word index; bit [DEPTH_LOG2+2] selects the control window.
- host_din  in  DATA_W  host write data.
- host_mwe  in  1  host write enable, already qualified by the host's decoder select.
- host_dout  out  DATA_W  host read data, 1-cycle registered.
- client_addr  in  32  client byte address, same bit layout as host_addr.
- client_din  in  DATA_W  client write data (control window only).
- client_mwe  in  1  client write enable, already qualified by the client's decoder select.
- client_dout  out  DATA_W  client read data, 1-cycle registered.
- irq_client  out  1  one-cycle pulse on swap commit.
- swap_pending  out  1  high while a host swap is waiting for client frame-done.

Behaviour:
- Storage: NUM_BUFS x 2^DEPTH_LOG2 words, inferred block RAM.
- Pointers: wr_idx (host back buffer) and rd_idx (client front buffer). Reset values: rd_idx=0, wr_idx=1.
- Host data writes (ctrl bit=0, host_mwe=1) go to buffer wr_idx at the word index.
- Host data reads return buffer wr_idx, so the host can read back its own frame.
- Client data reads return buffer rd_idx. Client data writes are ignored.
- Read latency is exactly 1 cycle on both ports. dout reflects the address sampled on the previous edge.
- Host write then host read of the same address returns the new data (read-after-write across cycles).
- Host control register, word 0 (ctrl bit=1):
  - Write bit0=1 requests a swap.
  - Read returns {overrun[7:0], frame_cnt[CNT_W-1:0], rd_idx[1:0], wr_idx[1:0], swap_pending}, zero-extended to DATA_W, LSB-packed in that order from bit 0 upward.
- Client control register, word 0:
  - Write bit0=1 signals frame_done.
  - Read returns the same status word.
- Other control-window word indices read as 0; writes to them are ignored.
- FSM with states IDLE and PENDING:
  - IDLE: on host swap request, go to PENDING.
  - PENDING: on client frame_done, commit and go to IDLE.
  - Frame_done while IDLE is a no-op.
  - Swap request and frame_done in the same cycle while IDLE: commit immediately, staying in IDLE. This is a zero-wait swap.
- Commit, in one cycle:
  - rd_idx <= wr_idx.
  - wr_idx <= (wr_idx+1) mod NUM_BUFS, skipping the new rd_idx. With NUM_BUFS=2 this equals the old rd_idx.
  - frame_cnt increments, wrapping.
  - irq_client pulses high for the following cycle only.
- Swap request while in PENDING: ignored, and overrun (8-bit) increments, saturating at 255.
- Host writes while in PENDING still land in wr_idx. Late writes become part of the pending frame.
- The host control write and the client frame_done both take effect at the clock edge on which mwe is sampled.
- Reset:
  - Outputs: host_dout=0, client_dout=0, irq_client=0, swap_pending=0.
  - State: FSM=IDLE; frame_cnt and overrun cleared; pointers as above.
  - RAM contents are not cleared.
  - Reset asserted mid-PENDING abandons the request; no irq is generated.

Decomposition:
- Shared package (beta_share_pkg): control-window bit position helper, status-word field offsets, FSM state encoding (IDLE=0, PENDING=1), swap/frame_done bit index.
- Sub-module frame_ring_ram: dual-port RAM with one read/write port and one read-only port, addressed by {buf_idx, word_idx}, 1-cycle registered reads.
- The top module holds the FSM, pointers, counters, control decode and output muxes.

Test Plan:
1. Reset release; client reads word 5.
   -> client_dout=0; status read = wr_idx=1, rd_idx=0, pending=0, cnt=0.
2. Host writes 0xDEADBEEF to word 5, host swap request, then client frame_done 10 cycles later.
   -> swap_pending high for those cycles.
   -> irq_client pulses once, the cycle after frame_done.
   -> client read of word 5 returns 0xDEADBEEF one cycle after address; status cnt=1.
3. Swap request and frame_done in the same cycle from IDLE.
   -> immediate commit, swap_pending never asserts, single irq.
4. Three swap requests while PENDING.
   -> overrun=3, only one commit on the next frame_done.
   -> 300 extra requests saturate overrun at 255.
5. NUM_BUFS=3: four commits.
   -> rd_idx sequence 1,2,0,1; wr_idx never equals rd_idx after any commit.
6. Reset asserted while PENDING.
   -> pending=0 and no irq on a following frame_done; previously written RAM data is still readable.
